exe_stage: RTL
==============

// Module: exe_stage
// PURPOSE
//  Execute stage; consumes the ID/EXE pipeline register outputs and feeds the EXE/MEM register.
//  Combinational ALU for arithmetic/logic/shift/move/jump groups, plus a sequential radix-2 divider FSM.
//  The divider holds the pipeline through stallreq_exe until the HI/LO result is ready.
//  Also raises the overflow exception code for ADD, ADDI and SUB.
// PARAMETERS
//  DIV_W   32  operand width of the divider; also the iteration count
// PORTS
//  cpu_clk_50M   in   1   clock, rising edge
//  cpu_rst       in   1   asynchronous, active-high reset
//  exe_alutype   in   `ALUTYPE_BUS  op group from ID/EXE
//  exe_aluop     in   `ALUOP_BUS    op code from ID/EXE
//  exe_src1/2    in   32  operands
//  exe_wa/wreg/mreg/din/whilo/ret_addr/pc/in_delay/exccode/badvaddr  in  -  ID/EXE payload
//  hi_i, lo_i    in   32  HI/LO already forwarded from MEM/WB
//  flush         in   1   exception flush
//  stall_nxt     in   1   stall[3]; 1 = EXE/MEM does not advance this cycle
//  stallreq_exe  out  1   pipeline stall request to stall control
//  exe_wd_o      out  32  GPR write data
//  exe_hilo_o    out  64  {HI,LO} write data
//  exe_exccode_o out  `EXC_CODE_BUS  exception code after overflow check
//  (all other ID/EXE payload fields pass through unchanged, suffixed _o)
// BEHAVIOUR
//  - Register state: div_st (IDLE/BUSY/DONE), cnt[5:0], rem[DIV_W:0], quo[DIV_W-1:0],
//    neg_q, neg_r, res_hi, res_lo. cpu_rst forces div_st=IDLE and every register to 0.
//  - Outputs: stallreq_exe=0, exe_hilo_o=0 in reset. All other outputs are combinational from inputs.
//  - ALU results: ADD/ADDU/SUB/SUBU, SLT/SLTU, AND/OR/XOR/NOR/LUI, SLL/SRL/SRA (shamt=src1[4:0]).
//    MFHI/MFLO return hi_i/lo_i. JUMP group returns ret_addr. MULT/MULTU return a one-cycle 64-bit product on exe_hilo_o.
//  - Overflow: ADD/ADDI/SUB with signed overflow and exe_exccode==`EXC_NONE give exccode_o=`EXC_OV and wreg_o=0.
//    Otherwise exccode passes through unchanged.
//  - FSM IDLE: aluop is DIV/DIVU and flush=0 -> stallreq_exe=1 (combinational).
//    Load |src1|,|src2| for DIV or the raw values for DIVU. neg_q=s1^s2, neg_r=s1. Set cnt=0 and go to BUSY.
//  - FSM BUSY: one restoring step per cycle: rem={rem,quo[msb]}; if rem>=divisor, subtract and shift in 1.
//    cnt++. At cnt==DIV_W-1 apply sign fix, write res_hi=rem and res_lo=quo, go to DONE. stallreq_exe=1 throughout.
//  - FSM DONE: stallreq_exe=0, exe_hilo_o={res_hi,res_lo}. Go to IDLE when stall_nxt=0; hold while stall_nxt=1.
//  - Latency: stallreq_exe is high for DIV_W+1 cycles starting at the DIV's first EXE cycle.
//    The result is presented in the following cycle.
//  - Divide by zero: runs the full iteration count; result HI=src1, LO=32'hFFFF_FFFF, no sign fix.
//  - flush in any state: next state IDLE, cnt=0. stallreq_exe is forced 0 in that same cycle.
//  - Asynchronous reset mid-division: abandons immediately. No partial result is ever presented.
//  - Back-to-back DIVs: the second DIV starts from IDLE in the cycle after DONE advances.
// CONFIGURATION
//  EXE_DIV_EARLY_EN defined:
//    - Divisor==0 or |dividend|<|divisor| skips BUSY; DONE is reached the cycle after issue.
//    - Early results: zero divisor -> HI=src1, LO=FFFF_FFFF. Small dividend -> HI=src1, LO=0.
//    - stallreq_exe is high for 1 cycle.
//  EXE_DIV_EARLY_EN undefined: every division takes DIV_W+1 stall cycles.
// TESTING
//  1 ADD 7FFF_FFFF+1, exccode NONE -> exccode_o=`EXC_OV, wreg_o=0. ADDU same -> wd=8000_0000.
//  2 DIVU 100/7 -> stallreq high 33 cycles, then hilo={2,14}; returns to IDLE when stall_nxt=0.
//  3 DIV -7/2 -> HI=FFFF_FFFF(-1), LO=FFFF_FFFD(-3). DIV 7/-2 -> HI=1, LO=FFFF_FFFD.
//  4 DIV by 0 -> HI=src1, LO=FFFF_FFFF. With EXE_DIV_EARLY_EN, stallreq high exactly 1 cycle.
//  5 flush at BUSY cycle 10 -> stallreq 0 that cycle, state IDLE, next DIV gives a correct result.
//  6 DONE held with stall_nxt=1 for 5 cycles -> hilo stable, stallreq 0. cpu_rst mid-BUSY -> all registers 0.

Source files
------------

// File: rtl/exe_stage.sv
// exe_stage: MIPS execute stage with a combinational ALU, overflow detection and a restoring radix-2 divider
//
// Ports
//   cpu_clk_50M, cpu_rst        clock (rising edge), asynchronous active-high reset
//   exe_alutype, exe_aluop      op group / op code from ID/EXE
//   exe_src1, exe_src2          operands (shift amount is exe_src1[4:0])
//   exe_wa .. exe_badvaddr      ID/EXE payload; re-emitted with an _o suffix
//   hi_i, lo_i                  forwarded HI/LO for MFHI/MFLO
//   flush                       exception flush, aborts a running division
//   stall_nxt                   EXE/MEM is held this cycle; keeps a finished quotient on display
//   stallreq_exe                stall request while a division is issuing or iterating
//   exe_wd_o                    GPR write data
//   exe_hilo_o                  {HI,LO} write data (MULT/MULTU product or division result)
//   exe_exccode_o               exception code after the ADD/ADDI/SUB overflow check
//
// Encodings: alutype JUMP=3'd5; aluop ADD=01 ADDU=02 ADDI=03 ADDIU=04 SUB=05 SUBU=06 SLT=07
//   SLTU=08 AND=09 OR=0A XOR=0B NOR=0C LUI=0D SLL=0E SRL=0F SRA=10 MFHI=11 MFLO=12 MULT=13
//   MULTU=14 DIV=15 DIVU=16; exccode NONE=5'h10 OV=5'h0C.
//
// Build option EXE_DIV_EARLY_EN: a zero divisor or a dividend smaller in magnitude than the
// divisor skips the iterations and finishes the cycle after issue.
`ifndef EXE_STAGE_DEFS
`define EXE_STAGE_DEFS
`define ALUTYPE_BUS 2:0
`define ALUOP_BUS 7:0
`define EXC_CODE_BUS 4:0
`define EXC_NONE 5'h10
`define EXC_OV 5'h0c
`endif

module exe_stage #(
    parameter int DIV_W = 32
) (
    input  logic                 cpu_clk_50M,
    input  logic                 cpu_rst,
    input  logic [`ALUTYPE_BUS]  exe_alutype,
    input  logic [`ALUOP_BUS]    exe_aluop,
    input  logic [31:0]          exe_src1,
    input  logic [31:0]          exe_src2,
    input  logic [4:0]           exe_wa,
    input  logic                 exe_wreg,
    input  logic                 exe_mreg,
    input  logic [31:0]          exe_din,
    input  logic                 exe_whilo,
    input  logic [31:0]          exe_ret_addr,
    input  logic [31:0]          exe_pc,
    input  logic                 exe_in_delay,
    input  logic [`EXC_CODE_BUS] exe_exccode,
    input  logic [31:0]          exe_badvaddr,
    input  logic [31:0]          hi_i,
    input  logic [31:0]          lo_i,
    input  logic                 flush,
    input  logic                 stall_nxt,
    output logic                 stallreq_exe,
    output logic [4:0]           exe_wa_o,
    output logic                 exe_wreg_o,
    output logic                 exe_mreg_o,
    output logic [31:0]          exe_din_o,
    output logic                 exe_whilo_o,
    output logic [31:0]          exe_ret_addr_o,
    output logic [31:0]          exe_pc_o,
    output logic                 exe_in_delay_o,
    output logic [`EXC_CODE_BUS] exe_exccode_o,
    output logic [31:0]          exe_badvaddr_o,
    output logic [31:0]          exe_wd_o,
    output logic [63:0]          exe_hilo_o
);
    localparam logic [2:0] T_JUMP = 3'd5;
    localparam logic [7:0] OP_ADD = 8'h01, OP_ADDU = 8'h02, OP_ADDI = 8'h03, OP_ADDIU = 8'h04,
                           OP_SUB = 8'h05, OP_SUBU = 8'h06, OP_SLT = 8'h07, OP_SLTU = 8'h08,
                           OP_AND = 8'h09, OP_OR = 8'h0a, OP_XOR = 8'h0b, OP_NOR = 8'h0c,
                           OP_LUI = 8'h0d, OP_SLL = 8'h0e, OP_SRL = 8'h0f, OP_SRA = 8'h10,
                           OP_MFHI = 8'h11, OP_MFLO = 8'h12, OP_MULT = 8'h13, OP_MULTU = 8'h14,
                           OP_DIV = 8'h15, OP_DIVU = 8'h16;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_st_t;

    logic [31:0] sum, dif, sra;
    logic [63:0] mul_s, mul_u;
    logic        is_add, is_sub, ov;

    assign sum    = exe_src1 + exe_src2;
    assign dif    = exe_src1 - exe_src2;
    // kept separate so the arithmetic shift is not turned logical by an unsigned ternary context
    assign sra    = $signed(exe_src2) >>> exe_src1[4:0];
    assign mul_s  = $signed(exe_src1) * $signed(exe_src2);
    assign mul_u  = {32'b0, exe_src1} * {32'b0, exe_src2};
    assign is_add = exe_aluop == OP_ADD || exe_aluop == OP_ADDI;
    assign is_sub = exe_aluop == OP_SUB;
    // an exception already carried by the instruction takes priority over overflow
    assign ov = exe_exccode == `EXC_NONE &&
                ((is_add && exe_src1[31] == exe_src2[31] && sum[31] != exe_src1[31]) ||
                 (is_sub && exe_src1[31] != exe_src2[31] && dif[31] != exe_src1[31]));

    always_comb begin
        exe_wd_o = (exe_alutype == T_JUMP) ? exe_ret_addr :
                   (exe_aluop == OP_ADD || exe_aluop == OP_ADDU ||
                    exe_aluop == OP_ADDI || exe_aluop == OP_ADDIU) ? sum :
                   (exe_aluop == OP_SUB || exe_aluop == OP_SUBU) ? dif :
                   (exe_aluop == OP_SLT)  ? {31'b0, $signed(exe_src1) < $signed(exe_src2)} :
                   (exe_aluop == OP_SLTU) ? {31'b0, exe_src1 < exe_src2} :
                   (exe_aluop == OP_AND)  ? exe_src1 & exe_src2 :
                   (exe_aluop == OP_OR)   ? exe_src1 | exe_src2 :
                   (exe_aluop == OP_XOR)  ? exe_src1 ^ exe_src2 :
                   (exe_aluop == OP_NOR)  ? ~(exe_src1 | exe_src2) :
                   (exe_aluop == OP_LUI)  ? {exe_src2[15:0], 16'b0} :
                   (exe_aluop == OP_SLL)  ? exe_src2 << exe_src1[4:0] :
                   (exe_aluop == OP_SRL)  ? exe_src2 >> exe_src1[4:0] :
                   (exe_aluop == OP_SRA)  ? sra :
                   (exe_aluop == OP_MFHI) ? hi_i :
                   (exe_aluop == OP_MFLO) ? lo_i : 32'b0;
    end

    assign exe_wa_o       = exe_wa;
    assign exe_wreg_o     = exe_wreg && !ov;
    assign exe_mreg_o     = exe_mreg;
    assign exe_din_o      = exe_din;
    assign exe_whilo_o    = exe_whilo;
    assign exe_ret_addr_o = exe_ret_addr;
    assign exe_pc_o       = exe_pc;
    assign exe_in_delay_o = exe_in_delay;
    assign exe_exccode_o  = ov ? `EXC_OV : exe_exccode;
    assign exe_badvaddr_o = exe_badvaddr;

    div_st_t          div_st_q;
    logic [5:0]       cnt_q;
    logic [DIV_W-1:0] rem_q, quo_q, dvs_q, res_hi_q, res_lo_q;
    logic             neg_quo_q, neg_rem_q;

    logic             is_div, div_sgn, src_zero, early, ge;
    logic [DIV_W-1:0] a_abs, b_abs, rem_d, quo_d;
    logic [DIV_W:0]   step;

    assign is_div   = exe_aluop == OP_DIV || exe_aluop == OP_DIVU;
    assign div_sgn  = exe_aluop == OP_DIV;
    assign a_abs    = (div_sgn && exe_src1[31]) ? -exe_src1 : exe_src1;
    assign b_abs    = (div_sgn && exe_src2[31]) ? -exe_src2 : exe_src2;
    assign src_zero = exe_src2 == '0;
`ifdef EXE_DIV_EARLY_EN
    assign early    = src_zero || a_abs < b_abs;
`else
    assign early    = 1'b0;
`endif
    // one restoring step: shift the next dividend bit into the partial remainder
    assign step  = {rem_q, quo_q[DIV_W-1]};
    assign ge    = step >= {1'b0, dvs_q};
    assign rem_d = ge ? step[DIV_W-1:0] - dvs_q : step[DIV_W-1:0];
    assign quo_d = {quo_q[DIV_W-2:0], ge};

    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            div_st_q  <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            res_hi_q  <= '0;
            res_lo_q  <= '0;
        end else if (flush) begin
            div_st_q <= IDLE;
            cnt_q    <= '0;
        end else begin
            case (div_st_q)
                IDLE: if (is_div) begin
                    if (early) begin
                        res_hi_q <= exe_src1;
                        res_lo_q <= src_zero ? '1 : '0;
                        div_st_q <= DONE;
                    end else begin
                        // a zero divisor iterates on the raw dividend so HI ends up as src1 itself
                        rem_q     <= '0;
                        quo_q     <= src_zero ? exe_src1 : a_abs;
                        dvs_q     <= b_abs;
                        neg_quo_q <= !src_zero && div_sgn && (exe_src1[31] ^ exe_src2[31]);
                        neg_rem_q <= !src_zero && div_sgn && exe_src1[31];
                        cnt_q     <= '0;
                        div_st_q  <= BUSY;
                    end
                end
                BUSY: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'(DIV_W - 1)) begin
                        res_hi_q <= neg_rem_q ? -rem_d : rem_d;
                        res_lo_q <= neg_quo_q ? -quo_d : quo_d;
                        div_st_q <= DONE;
                    end
                end
                DONE: if (!stall_nxt) div_st_q <= IDLE;
                default: div_st_q <= IDLE;
            endcase
        end
    end

    assign stallreq_exe = !cpu_rst && !flush &&
                          (div_st_q == BUSY || (div_st_q == IDLE && is_div));
    assign exe_hilo_o = cpu_rst ? 64'b0 :
                        (div_st_q == DONE) ? {res_hi_q, res_lo_q} :
                        (exe_aluop == OP_MULT) ? mul_s :
                        (exe_aluop == OP_MULTU) ? mul_u : 64'b0;
endmodule
